// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage of the single-cycle RV64 core.
// Holds the architectural PC and fetches the 32-bit word at PC over an
// AXI-lite-style read channel (address phase, then data phase). The fetched
// word is presented to decode until control commits the instruction. On commit
// the PC takes the next-PC value chosen by the control unit.
module inst_fetch_unit #(
  parameter int unsigned       XLEN     = 64,
  parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      sel_nextpc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] c_rdata,
  input  logic            inst_update,
  input  logic            mem_finish,
  output logic [31:0]     araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [XLEN-1:0] cpupc,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] dnpc,
  output logic            fetch_err,
  output logic            misalign
);

  // FSM encodings
  localparam logic [1:0] ST_FETCH = 2'd0;  // address phase: arvalid high
  localparam logic [1:0] ST_WAIT  = 2'd1;  // data phase: rready high
  localparam logic [1:0] ST_READY = 2'd2;  // instruction presented, waiting to retire

  localparam logic [1:0] SEL_SEQ  = 2'd0;
  localparam logic [1:0] SEL_BR   = 2'd1;
  localparam logic [1:0] SEL_JALR = 2'd2;
  localparam logic [1:0] SEL_CSR  = 2'd3;

  logic [1:0]      state_q,      state_d;
  logic [XLEN-1:0] pc_q,         pc_d;
  logic [31:0]     inst_q,       inst_d;
  logic            inst_valid_q, inst_valid_d;
  logic            fetch_err_q,  fetch_err_d;

  logic            ar_fire;
  logic            r_fire;
  logic            commit;
  logic [31:0]     fetched_word;
  logic [XLEN-1:0] next_pc;

  // Next-PC selection; all sums wrap modulo 2^XLEN
  always_comb begin
    next_pc = pc_q + XLEN'(4);
    unique case (sel_nextpc)
      SEL_SEQ:  next_pc = pc_q + XLEN'(4);
      SEL_BR:   next_pc = pc_q + imm;
      SEL_JALR: next_pc = (src1 + imm) & ~XLEN'(1);
      SEL_CSR:  next_pc = c_rdata;
      default:  next_pc = pc_q + XLEN'(4);
    endcase
  end

  // Handshakes and word select from the 8-byte beat. A data beat is taken
  // only in WAIT, so rvalid coinciding with arready in FETCH is ignored.
  always_comb begin
    ar_fire      = (state_q == ST_FETCH) && arready;
    r_fire       = (state_q == ST_WAIT) && rvalid;
    commit       = (state_q == ST_READY) && inst_update && mem_finish && inst_valid_q;
    fetched_word = pc_q[2] ? rdata[63:32] : rdata[31:0];
  end

  // Fetch FSM and architectural state update
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    fetch_err_d  = fetch_err_q;
    unique case (state_q)
      ST_FETCH: begin
        if (ar_fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_fire) begin
          inst_d       = fetched_word;
          inst_valid_d = 1'b1;
          if (rresp != 2'b00) begin
            fetch_err_d = 1'b1;
          end
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (commit) begin
          pc_d         = next_pc;
          inst_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State registers with asynchronous reset; reset aborts any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  // Output decode; araddr is derived from the held PC so it is stable in FETCH
  always_comb begin
    arvalid    = (state_q == ST_FETCH);
    rready     = (state_q == ST_WAIT);
    araddr     = {pc_q[31:3], 3'b000};
    cpupc      = pc_q;
    inst       = inst_q;
    inst_valid = inst_valid_q;
    fetch_err  = fetch_err_q;
    dnpc       = next_pc;
    misalign   = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit.
module tb_inst_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] PAIR   = 64'h00100093_00000013;

  logic        clk;
  logic        rst;
  logic [1:0]  sel_nextpc;
  logic [63:0] imm;
  logic [63:0] src1;
  logic [63:0] c_rdata;
  logic        inst_update;
  logic        mem_finish;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [63:0] cpupc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [63:0] dnpc;
  logic        fetch_err;
  logic        misalign;

  int unsigned n_checks;
  int unsigned n_fail;

  inst_fetch_unit #(
    .XLEN     (64),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel_nextpc  (sel_nextpc),
    .imm         (imm),
    .src1        (src1),
    .c_rdata     (c_rdata),
    .inst_update (inst_update),
    .mem_finish  (mem_finish),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .cpupc       (cpupc),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .dnpc        (dnpc),
    .fetch_err   (fetch_err),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Address handshake then one data beat; leaves the DUT in READY
  task automatic fetch(input logic [63:0] data, input logic [1:0] resp,
                       input logic [31:0] exp_addr, input logic [31:0] exp_inst);
    check("fetch_arvalid", {63'd0, arvalid}, 64'd1);
    check("fetch_araddr", {32'd0, araddr}, {32'd0, exp_addr});
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("wait_rready", {62'd0, rready, arvalid}, 64'd2);
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    tick();
    rvalid = 1'b0;
    rresp  = 2'b00;
    rdata  = '0;
    check("ready_valid", {63'd0, inst_valid}, 64'd1);
    check("ready_inst", {32'd0, inst}, {32'd0, exp_inst});
  endtask

  task automatic commit(input logic [1:0] sel, input logic [63:0] im,
                        input logic [63:0] s1, input logic [63:0] crd,
                        input logic [63:0] exp_pc);
    sel_nextpc  = sel;
    imm         = im;
    src1        = s1;
    c_rdata     = crd;
    #1;
    check("commit_dnpc", dnpc, exp_pc);
    inst_update = 1'b1;
    mem_finish  = 1'b1;
    tick();
    inst_update = 1'b0;
    mem_finish  = 1'b0;
    check("commit_pc", cpupc, exp_pc);
    check("commit_clear", {62'd0, inst_valid, arvalid}, 64'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    sel_nextpc  = 2'd0;
    imm         = '0;
    src1        = '0;
    c_rdata     = '0;
    inst_update = 1'b0;
    mem_finish  = 1'b0;
    arready     = 1'b0;
    rdata       = '0;
    rresp       = 2'b00;
    rvalid      = 1'b0;
    #2;
    check("rst_pc", cpupc, RST_PC);
    check("rst_flags", {60'd0, inst_valid, fetch_err, rready, arvalid}, 64'd1);
    check("rst_inst", {32'd0, inst}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // 1: rvalid together with arready is not taken; first word from low half
    arready = 1'b1;
    rvalid  = 1'b1;
    rdata   = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    arready = 1'b0;
    check("early_rvalid_ignored", {62'd0, inst_valid, rready}, 64'd1);
    rdata = PAIR;
    tick();
    rvalid = 1'b0;
    check("t1_inst", {32'd0, inst}, 64'h13);
    check("t1_valid", {63'd0, inst_valid}, 64'd1);
    commit(2'd0, '0, '0, '0, 64'h8000_0004);

    // 2: upper word, branch backwards by 8
    fetch(PAIR, 2'b00, 32'h8000_0000, 32'h0010_0093);
    commit(2'd1, -64'sd8, '0, '0, 64'h7FFF_FFFC);

    // 3: misaligned indication, jalr LSB clear, then CSR target
    fetch(PAIR, 2'b00, 32'h7FFF_FFF8, 32'h0010_0093);
    sel_nextpc = 2'd1;
    imm        = 64'd2;
    #1;
    check("misalign_set", {63'd0, misalign}, 64'd1);
    check("misalign_dnpc", dnpc, 64'h7FFF_FFFE);
    sel_nextpc = 2'd2;
    src1       = 64'h8000_1001;
    imm        = 64'd4;
    #1;
    check("jalr_dnpc", dnpc, 64'h8000_1004);
    check("jalr_aligned", {63'd0, misalign}, 64'd0);
    commit(2'd3, '0, '0, 64'h8000_0100, 64'h8000_0100);

    // 4: address stall with stray retire requests, then mem_finish stall
    inst_update = 1'b1;
    mem_finish  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_arvalid", {63'd0, arvalid}, 64'd1);
      check("stall_araddr", {32'd0, araddr}, 64'h8000_0100);
      check("stall_pc", cpupc, 64'h8000_0100);
    end
    inst_update = 1'b0;
    mem_finish  = 1'b0;
    fetch(PAIR, 2'b00, 32'h8000_0100, 32'h13);
    sel_nextpc  = 2'd0;
    inst_update = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("memwait_pc", cpupc, 64'h8000_0100);
      check("memwait_valid", {63'd0, inst_valid}, 64'd1);
    end
    mem_finish = 1'b1;
    tick();
    check("single_update_a", cpupc, 64'h8000_0104);
    tick();
    tick();
    check("single_update_b", cpupc, 64'h8000_0104);
    inst_update = 1'b0;
    mem_finish  = 1'b0;

    // 5: error response is sticky; instruction still presented and retired
    fetch(PAIR, 2'b10, 32'h8000_0100, 32'h0010_0093);
    check("err_set", {63'd0, fetch_err}, 64'd1);
    commit(2'd0, '0, '0, '0, 64'h8000_0108);
    fetch(PAIR, 2'b00, 32'h8000_0108, 32'h13);
    check("err_sticky", {63'd0, fetch_err}, 64'd1);
    commit(2'd0, '0, '0, '0, 64'h8000_010C);

    // 6: reset during WAIT aborts; late beat is dropped
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("pre_rst_wait", {63'd0, rready}, 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_pc", cpupc, RST_PC);
    check("async_rst_flags", {60'd0, inst_valid, fetch_err, rready, arvalid}, 64'd1);
    #1;
    rst    = 1'b0;
    rvalid = 1'b1;
    rdata  = PAIR;
    tick();
    rvalid = 1'b0;
    check("late_rvalid_dropped", {62'd0, inst_valid, arvalid}, 64'd1);

    // PC wrap through the top of the address space
    fetch(PAIR, 2'b00, 32'h8000_0000, 32'h13);
    commit(2'd3, '0, '0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(PAIR, 2'b00, 32'hFFFF_FFF8, 32'h0010_0093);
    commit(2'd0, '0, '0, '0, 64'h0);
    check("wrap_araddr", {32'd0, araddr}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
